// File: rtl/sram_req_ctrl.sv
// Request/response front end for the 512x32 1RW+1R OpenRAM macro.
// Maps two valid/ready request streams onto macro pins and returns read data through credit-managed FIFOs.

module sram_rsp_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop_ready,
    output logic                         rsp_valid,
    output logic [WIDTH-1:0]             rsp_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             valid_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             pop_c;

    assign pop_c     = pop_ready & valid_q;
    assign rsp_valid = valid_q;
    assign rsp_data  = head_q;
    assign count     = count_q;

    // Next head: the element behind the popped one, or the pushed word when it lands in an empty slot.
    always_comb begin
        count_d = count_q + CNT_W'(push) - CNT_W'(pop_c);
        head_d  = head_q;
        if (count_d == '0) begin
            head_d = '0;
        end else if (pop_c) begin
            head_d = (count_q == CNT_W'(1)) ? push_data : mem[rd_ptr_q + PTR_W'(1)];
        end else if (count_q == '0) begin
            head_d = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_c) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
            head_q  <= head_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q] <= push_data;
    end

endmodule

module sram_req_ctrl #(
    parameter int unsigned ADDR_WIDTH = 9,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NUM_WMASKS = 4,
    parameter int unsigned RSP_DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic                   a_req_valid,
    output logic                   a_req_ready,
    input  logic                   a_req_we,
    input  logic [NUM_WMASKS-1:0]  a_req_wmask,
    input  logic [ADDR_WIDTH-1:0]  a_req_addr,
    input  logic [DATA_WIDTH-1:0]  a_req_wdata,
    output logic                   a_rsp_valid,
    input  logic                   a_rsp_ready,
    output logic [DATA_WIDTH-1:0]  a_rsp_rdata,

    input  logic                   b_req_valid,
    output logic                   b_req_ready,
    input  logic [ADDR_WIDTH-1:0]  b_req_addr,
    output logic                   b_rsp_valid,
    input  logic                   b_rsp_ready,
    output logic [DATA_WIDTH-1:0]  b_rsp_rdata,

    output logic                   sram_csb0,
    output logic                   sram_web0,
    output logic [NUM_WMASKS-1:0]  sram_wmask0,
    output logic [ADDR_WIDTH-1:0]  sram_addr0,
    output logic [DATA_WIDTH-1:0]  sram_din0,
    input  logic [DATA_WIDTH-1:0]  sram_dout0,

    output logic                   sram_csb1,
    output logic [ADDR_WIDTH-1:0]  sram_addr1,
    input  logic [DATA_WIDTH-1:0]  sram_dout1
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

    logic             a_inflight_q;
    logic             b_inflight_q;
    logic [CNT_W-1:0] a_count;
    logic [CNT_W-1:0] b_count;
    logic [CNT_W:0]   a_used_c;
    logic [CNT_W:0]   b_used_c;
    logic             a_credit_c;
    logic             b_credit_c;
    logic             a_fire_c;
    logic             b_fire_c;
    logic             hazard_c;

    // Credit comes from registered state only, so a pop frees a slot one cycle later.
    assign a_used_c   = {1'b0, a_count} + (CNT_W+1)'(a_inflight_q);
    assign b_used_c   = {1'b0, b_count} + (CNT_W+1)'(b_inflight_q);
    assign a_credit_c = a_used_c < (CNT_W+1)'(RSP_DEPTH);
    assign b_credit_c = b_used_c < (CNT_W+1)'(RSP_DEPTH);

    assign a_req_ready = a_credit_c & rst_n;
    assign a_fire_c    = a_req_valid & a_req_ready;

    // Port B must not read a word that port A writes at the same edge.
    assign hazard_c    = a_fire_c & a_req_we & (a_req_addr == b_req_addr);
    assign b_req_ready = b_credit_c & rst_n & ~hazard_c;
    assign b_fire_c    = b_req_valid & b_req_ready;

    assign sram_csb0   = ~a_fire_c;
    assign sram_web0   = ~a_req_we;
    assign sram_wmask0 = a_req_wmask;
    assign sram_addr0  = a_req_addr;
    assign sram_din0   = a_req_wdata;
    assign sram_csb1   = ~b_fire_c;
    assign sram_addr1  = b_req_addr;

    // The macro drives dout on the negedge after the sampling edge; capture it one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_inflight_q <= 1'b0;
            b_inflight_q <= 1'b0;
        end else begin
            a_inflight_q <= a_fire_c & ~a_req_we;
            b_inflight_q <= b_fire_c;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_a_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (a_inflight_q),
        .push_data (sram_dout0),
        .pop_ready (a_rsp_ready),
        .rsp_valid (a_rsp_valid),
        .rsp_data  (a_rsp_rdata),
        .count     (a_count)
    );

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_b_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (b_inflight_q),
        .push_data (sram_dout1),
        .pop_ready (b_rsp_ready),
        .rsp_valid (b_rsp_valid),
        .rsp_data  (b_rsp_rdata),
        .count     (b_count)
    );

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Directed bench for sram_req_ctrl with a behavioural model of the 1RW+1R macro
// (inputs registered on posedge, access on the following negedge).

module tb_sram_req_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req_valid, a_req_ready, a_req_we;
    logic [3:0]  a_req_wmask;
    logic [8:0]  a_req_addr;
    logic [31:0] a_req_wdata;
    logic        a_rsp_valid, a_rsp_ready;
    logic [31:0] a_rsp_rdata;
    logic        b_req_valid, b_req_ready;
    logic [8:0]  b_req_addr;
    logic        b_rsp_valid, b_rsp_ready;
    logic [31:0] b_rsp_rdata;
    logic        sram_csb0, sram_web0, sram_csb1;
    logic [3:0]  sram_wmask0;
    logic [8:0]  sram_addr0, sram_addr1;
    logic [31:0] sram_din0, sram_dout0, sram_dout1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sram_req_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
        .a_req_wmask(a_req_wmask), .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata),
        .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
        .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_addr(b_req_addr),
        .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
        .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
        .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0),
        .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
    );

    // Macro model
    logic [31:0] mem [512];
    logic        m_csb0, m_web0, m_csb1;
    logic [3:0]  m_wmask0;
    logic [8:0]  m_addr0, m_addr1;
    logic [31:0] m_din0;

    always @(posedge clk) begin
        m_csb0   <= sram_csb0;
        m_web0   <= sram_web0;
        m_wmask0 <= sram_wmask0;
        m_addr0  <= sram_addr0;
        m_din0   <= sram_din0;
        m_csb1   <= sram_csb1;
        m_addr1  <= sram_addr1;
    end

    always @(negedge clk) begin
        if (m_csb0 === 1'b0) begin
            if (m_web0 === 1'b0) begin
                for (int i = 0; i < 4; i++)
                    if (m_wmask0[i]) mem[m_addr0][i*8 +: 8] = m_din0[i*8 +: 8];
            end else begin
                sram_dout0 <= mem[m_addr0];
            end
        end
        if (m_csb1 === 1'b0) sram_dout1 <= mem[m_addr1];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        is_b;
        logic        we;
        logic [3:0]  wmask;
        logic [8:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } op_t;

    op_t vec [10];

    function automatic logic [31:0] sdata(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0101_0101;
    endfunction

    // Issue one op starting just after a posedge; reads are checked for one-cycle latency and data.
    task automatic do_op(input op_t op, input string name);
        logic acc;
        logic r;
        acc = 1'b0;
        if (op.is_b) begin
            b_req_valid = 1'b1; b_req_addr = op.addr;
        end else begin
            a_req_valid = 1'b1; a_req_we = op.we; a_req_wmask = op.wmask;
            a_req_addr = op.addr; a_req_wdata = op.wdata;
        end
        for (int c = 0; c < 20 && !acc; c++) begin
            @(negedge clk);
            r = op.is_b ? b_req_ready : a_req_ready;
            @(posedge clk);
            acc = r;
            #1;
        end
        a_req_valid = 1'b0;
        b_req_valid = 1'b0;
        check({name, "_accept"}, 32'(acc), 32'd1);
        if (!op.we || op.is_b) begin
            @(negedge clk);
            check({name, "_early_valid"}, 32'(op.is_b ? b_rsp_valid : a_rsp_valid), 32'd0);
            @(negedge clk);
            check({name, "_valid"}, 32'(op.is_b ? b_rsp_valid : a_rsp_valid), 32'd1);
            check({name, "_rdata"}, op.is_b ? b_rsp_rdata : a_rsp_rdata, op.exp);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic r;
        int   acc;
        int   idx;
        logic [8:0] blist [4];

        for (int i = 0; i < 512; i++) mem[i] = '0;
        sram_dout0 = '0; sram_dout1 = '0;
        rst_n = 1'b0;
        a_req_valid = 0; a_req_we = 0; a_req_wmask = 0; a_req_addr = 0; a_req_wdata = 0;
        b_req_valid = 0; b_req_addr = 0;
        a_rsp_ready = 1; b_rsp_ready = 1;

        vec[0] = '{1'b0, 1'b1, 4'hF,    9'h005, 32'hDEADBEEF, 32'h0};
        vec[1] = '{1'b0, 1'b0, 4'h0,    9'h005, 32'h0,        32'hDEADBEEF};
        vec[2] = '{1'b0, 1'b1, 4'hF,    9'h1FF, 32'h11223344, 32'h0};
        vec[3] = '{1'b0, 1'b1, 4'b0010, 9'h1FF, 32'h0000AB00, 32'h0};
        vec[4] = '{1'b1, 1'b0, 4'h0,    9'h1FF, 32'h0,        32'h1122AB44};
        vec[5] = '{1'b0, 1'b0, 4'h0,    9'h1FF, 32'h0,        32'h1122AB44};
        vec[6] = '{1'b0, 1'b1, 4'b1001, 9'h020, 32'hCAFEF00D, 32'h0};
        vec[7] = '{1'b1, 1'b0, 4'h0,    9'h020, 32'h0,        32'hCA00000D};
        vec[8] = '{1'b1, 1'b0, 4'h0,    9'h005, 32'h0,        32'hDEADBEEF};
        vec[9] = '{1'b0, 1'b1, 4'hF,    9'h011, 32'h01100110, 32'h0};

        // Reset state, with requests pending to show the chip selects stay off
        a_req_valid = 1; b_req_valid = 1;
        #12;
        check("rst_a_ready", 32'(a_req_ready), 32'd0);
        check("rst_b_ready", 32'(b_req_ready), 32'd0);
        check("rst_csb0",    32'(sram_csb0),   32'd1);
        check("rst_csb1",    32'(sram_csb1),   32'd1);
        check("rst_a_valid", 32'(a_rsp_valid), 32'd0);
        check("rst_b_rdata", b_rsp_rdata,      32'd0);
        a_req_valid = 0; b_req_valid = 0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) do_op(vec[i], $sformatf("vec%0d", i));

        // Write/read collision on 0x010: B held off one cycle, then sees new data
        a_req_valid = 1; a_req_we = 1; a_req_wmask = 4'hF; a_req_addr = 9'h010; a_req_wdata = 32'h5A5A1234;
        b_req_valid = 1; b_req_addr = 9'h010;
        @(negedge clk);
        check("hz_b_ready_blocked", 32'(b_req_ready), 32'd0);
        check("hz_a_ready",         32'(a_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 0;
        @(negedge clk);
        check("hz_b_ready_next", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        b_req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("hz_b_valid", 32'(b_rsp_valid), 32'd1);
        check("hz_b_rdata", b_rsp_rdata, 32'h5A5A1234);
        @(posedge clk); #1;

        // Different address in the same cycle is not blocked
        a_req_valid = 1; a_req_we = 1; a_req_addr = 9'h012; a_req_wdata = 32'h77777777;
        b_req_valid = 1; b_req_addr = 9'h011;
        @(negedge clk);
        check("nohz_b_ready", 32'(b_req_ready), 32'd1);
        @(posedge clk); #1;
        a_req_valid = 0; b_req_valid = 0;
        @(negedge clk);
        @(negedge clk);
        check("nohz_b_rdata", b_rsp_rdata, 32'h01100110);
        @(posedge clk); #1;

        // Backpressure on B: exactly RSP_DEPTH reads accepted
        blist[0] = 9'h005; blist[1] = 9'h1FF; blist[2] = 9'h020; blist[3] = 9'h011;
        b_rsp_ready = 0; acc = 0; idx = 0;
        b_req_valid = 1; b_req_addr = blist[0];
        for (int c = 0; c < 4; c++) begin
            @(negedge clk); r = b_req_ready;
            @(posedge clk);
            if (r) begin acc++; idx++; end
            #1 b_req_addr = blist[idx];
        end
        check("bp_accepted", 32'(acc), 32'd2);
        @(negedge clk);
        check("bp_b_ready_low", 32'(b_req_ready), 32'd0);
        check("bp_head",        b_rsp_rdata,      32'hDEADBEEF);
        b_rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_ready_after_pop", 32'(b_req_ready), 32'd1);
        check("bp_second",          b_rsp_rdata,      32'h1122AB44);
        @(posedge clk); #1;
        b_req_valid = 0;
        @(negedge clk);
        check("bp_empty_gap", 32'(b_rsp_valid), 32'd0);
        @(negedge clk);
        check("bp_third_valid", 32'(b_rsp_valid), 32'd1);
        check("bp_third",       b_rsp_rdata,      32'hCA00000D);
        @(posedge clk); #1;

        // Streaming: load 16 words, then read them on both ports concurrently
        for (int i = 0; i < 16; i++) begin
            op_t w;
            w = '{1'b0, 1'b1, 4'hF, 9'h100 + 9'(i), sdata(i), 32'h0};
            do_op(w, $sformatf("sw%0d", i));
        end
        fork
            begin
                int ia;
                logic ra;
                ia = 0;
                a_req_valid = 1; a_req_we = 0; a_req_addr = 9'h100;
                for (int c = 0; c < 200 && ia < 16; c++) begin
                    @(negedge clk); ra = a_req_ready;
                    @(posedge clk);
                    if (ra) ia++;
                    #1 a_req_addr = 9'h100 + 9'(ia);
                end
                a_req_valid = 0;
            end
            begin
                int ib;
                logic rb;
                ib = 0;
                b_req_valid = 1; b_req_addr = 9'h10F;
                for (int c = 0; c < 200 && ib < 16; c++) begin
                    @(negedge clk); rb = b_req_ready;
                    @(posedge clk);
                    if (rb) ib++;
                    #1 b_req_addr = 9'h10F - 9'(ib);
                end
                b_req_valid = 0;
            end
            begin
                int na;
                na = 0;
                for (int c = 0; c < 200 && na < 16; c++) begin
                    @(negedge clk);
                    if (a_rsp_valid) begin
                        check($sformatf("stream_a%0d", na), a_rsp_rdata, sdata(na));
                        na++;
                    end
                end
                check("stream_a_count", 32'(na), 32'd16);
            end
            begin
                int nb;
                nb = 0;
                for (int c = 0; c < 200 && nb < 16; c++) begin
                    @(negedge clk);
                    if (b_rsp_valid) begin
                        check($sformatf("stream_b%0d", nb), b_rsp_rdata, sdata(15 - nb));
                        nb++;
                    end
                end
                check("stream_b_count", 32'(nb), 32'd16);
            end
        join
        @(posedge clk); #1;

        // Reset one cycle after a read accept: the read must vanish
        a_req_valid = 1; a_req_we = 0; a_req_addr = 9'h005;
        b_req_valid = 1; b_req_addr = 9'h005;
        @(negedge clk); r = a_req_ready;
        check("mr_accept", 32'(r), 32'd1);
        @(posedge clk); #1;
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("mr_a_ready", 32'(a_req_ready), 32'd0);
        check("mr_csb0",    32'(sram_csb0),   32'd1);
        check("mr_csb1",    32'(sram_csb1),   32'd1);
        check("mr_a_valid", 32'(a_rsp_valid), 32'd0);
        check("mr_a_rdata", a_rsp_rdata,      32'd0);
        @(negedge clk);
        check("mr_a_valid_hold", 32'(a_rsp_valid), 32'd0);
        check("mr_b_valid_hold", 32'(b_rsp_valid), 32'd0);
        a_req_valid = 0; b_req_valid = 0;
        rst_n = 1'b1;
        #1;
        check("mr_ready_after", 32'(a_req_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("mr_no_rsp%0d", c), 32'(a_rsp_valid), 32'd0);
            check($sformatf("mr_rdata0_%0d", c), a_rsp_rdata, 32'd0);
        end
        @(posedge clk); #1;
        do_op(vec[1], "post_rst_read");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
